// File: rtl/comp_sequencer.sv
// rtl/comp_sequencer.sv - per-period sample / compensate / duty-update sequencer for a digital PWM loop
module comp_sequencer #(
    parameter int PERIOD      = 512,
    parameter int SAMPLE_PT   = 400,
    parameter int ADC_TIMEOUT = 64,
    parameter int DUTY_MAX    = 486
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] vref,
    output logic       adc_start,
    input  logic       adc_done,
    input  logic [7:0] adc_data,
    output logic [3:0] e_n_out,
    output logic       comp_step,
    input  logic [8:0] d_n_in,
    output logic [8:0] duty,
    output logic [8:0] cnt,
    output logic       period_start,
    output logic       adc_fault
);

    localparam int              TW         = $clog2(ADC_TIMEOUT + 1);
    localparam logic [8:0]      CNT_LAST   = 9'(PERIOD - 1);
    localparam logic [8:0]      CNT_SAMPLE = 9'(SAMPLE_PT);
    localparam logic [8:0]      DUTY_LIM   = 9'(DUTY_MAX);
    localparam logic [TW-1:0]   CONV_LAST  = TW'(ADC_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SAMPLE,
        CONVERT,
        STEP,
        SETTLE,
        WAIT_PERIOD
    } state_t;

    state_t state, state_nxt;

    // conv_cnt counts cycles since adc_start, so the adc_start cycle itself is cycle 0
    logic [TW-1:0]    conv_cnt;
    logic             settle_cnt;
    logic [8:0]       duty_pend;
    logic [8:0]       duty_clamped;
    logic signed [8:0] err;
    logic [3:0]       err_sat;

    logic cnt_wrap;
    logic conv_accept;
    logic conv_expire;
    logic settle_done;

    assign cnt_wrap     = (cnt == CNT_LAST);
    assign adc_start    = (state == WAIT_SAMPLE) && (cnt == CNT_SAMPLE);
    assign period_start = (state != IDLE) && (cnt == 9'd0);

    // a done pulse on the last timeout cycle still counts as a good conversion
    assign conv_accept  = (state == CONVERT) && adc_done;
    assign conv_expire  = (state == CONVERT) && !adc_done && (conv_cnt == CONV_LAST);
    assign settle_done  = (state == SETTLE) && settle_cnt;

    assign err          = $signed({1'b0, vref}) - $signed({1'b0, adc_data});
    assign duty_clamped = (d_n_in > DUTY_LIM) ? DUTY_LIM : d_n_in;

    // saturate the raw error into the compensator's -4..+4 input range
    always_comb begin
        if (err > 9'sd4) begin
            err_sat = 4'b0100;
        end else if (err < -9'sd4) begin
            err_sat = 4'b1100;
        end else begin
            err_sat = err[3:0];
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic; dropping enable always returns to IDLE
    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:        state_nxt = WAIT_SAMPLE;
                WAIT_SAMPLE: if (adc_start) state_nxt = CONVERT;
                CONVERT: begin
                    if (conv_accept) begin
                        state_nxt = STEP;
                    end else if (conv_expire) begin
                        state_nxt = WAIT_PERIOD;
                    end
                end
                STEP:        state_nxt = SETTLE;
                SETTLE:      if (settle_done) state_nxt = WAIT_PERIOD;
                WAIT_PERIOD: if (cnt_wrap) state_nxt = WAIT_SAMPLE;
                default:     state_nxt = IDLE;
            endcase
        end
    end

    // period counter, error/duty registers and the sticky fault flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= 9'd0;
            duty       <= 9'd0;
            duty_pend  <= 9'd0;
            e_n_out    <= 4'd0;
            comp_step  <= 1'b0;
            conv_cnt   <= '0;
            settle_cnt <= 1'b0;
            adc_fault  <= 1'b0;
        end else if (!enable || state == IDLE) begin
            cnt        <= 9'd0;
            duty       <= 9'd0;
            duty_pend  <= 9'd0;
            e_n_out    <= 4'd0;
            comp_step  <= 1'b0;
            conv_cnt   <= '0;
            settle_cnt <= 1'b0;
        end else begin
            cnt        <= cnt_wrap ? 9'd0 : cnt + 9'd1;
            comp_step  <= conv_accept;
            settle_cnt <= (state == SETTLE) ? ~settle_cnt : 1'b0;

            if (adc_start) begin
                conv_cnt <= TW'(1);
            end else if (state == CONVERT) begin
                conv_cnt <= conv_cnt + TW'(1);
            end

            if (conv_accept) begin
                e_n_out <= err_sat;
            end else if (conv_expire) begin
                e_n_out   <= 4'd0;
                adc_fault <= 1'b1;
            end

            if (settle_done) begin
                duty_pend <= duty_clamped;
            end

            if (state == WAIT_PERIOD && cnt_wrap) begin
                duty <= duty_pend;
            end
        end
    end

endmodule

// File: tb/tb_comp_sequencer.sv
// tb/tb_comp_sequencer.sv - scoreboard bench for comp_sequencer
module tb_comp_sequencer;

    localparam int SAMPLE_PT = 400;
    localparam int DUTY_MAX  = 486;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] vref;
    logic       adc_start;
    logic       adc_done;
    logic [7:0] adc_data;
    logic [3:0] e_n_out;
    logic       comp_step;
    logic [8:0] d_n_in;
    logic [8:0] duty;
    logic [8:0] cnt;
    logic       period_start;
    logic       adc_fault;

    comp_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .vref         (vref),
        .adc_start    (adc_start),
        .adc_done     (adc_done),
        .adc_data     (adc_data),
        .e_n_out      (e_n_out),
        .comp_step    (comp_step),
        .d_n_in       (d_n_in),
        .duty         (duty),
        .cnt          (cnt),
        .period_start (period_start),
        .adc_fault    (adc_fault)
    );

    int vectors;
    int miscompares;
    int duty_model;
    int fault_model;
    int exp_duty[$];
    int exp_step_e[$];
    int exp_step_cnt[$];
    int prev_duty;
    int prev_adc_start;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_err(input int v, input int a);
        int e;
        logic [3:0] code;
        e = v - a;
        if (e > 4) e = 4;
        if (e < -4) e = -4;
        code = 4'(e);
        return int'(code);
    endfunction

    task automatic wait_adc_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (adc_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL adc_start_wait: got no adc_start, expected one within 1100 cycles");
        end
    endtask

    // k: 1..63 done k cycles after adc_start; 64 done one cycle too late; other = no done
    task automatic run_period(input int v, input int a, input int k, input int dn);
        bit ok;
        vref     = 8'(v);
        adc_data = 8'(a);
        d_n_in   = 9'(dn);
        wait_adc_start(ok);
        if (!ok) return;
        if (k >= 1 && k <= 63) begin
            exp_step_e.push_back(model_err(v, a));
            exp_step_cnt.push_back(SAMPLE_PT + k + 1);
            duty_model = (dn > DUTY_MAX) ? DUTY_MAX : dn;
            exp_duty.push_back(duty_model);
            repeat (k) @(negedge clk);
            adc_done = 1'b1;
            @(negedge clk);
            adc_done = 1'b0;
            repeat (6) @(negedge clk);
        end else begin
            exp_duty.push_back(duty_model);
            repeat (63) @(negedge clk);
            check("fault_before_timeout", int'(adc_fault), fault_model);
            @(negedge clk);
            check("fault_at_timeout", int'(adc_fault), 1);
            check("e_n_out_on_timeout", int'(e_n_out), 0);
            fault_model = 1;
            if (k == 64) adc_done = 1'b1;
            @(negedge clk);
            adc_done = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a step or a period start
    always @(negedge clk) begin
        if (comp_step === 1'b1) begin
            if (exp_step_e.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL comp_step_unexpected: got comp_step=1 at cnt %0d, expected none", cnt);
            end else begin
                check("e_n_out", int'(e_n_out), exp_step_e.pop_front());
                check("comp_step_cnt", int'(cnt), exp_step_cnt.pop_front());
            end
        end
        if (period_start === 1'b1) begin
            if (exp_duty.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL period_start_unexpected: got period_start with duty %0d, expected none", duty);
            end else begin
                check("duty_at_wrap", int'(duty), exp_duty.pop_front());
            end
        end
        if (adc_start === 1'b1) begin
            check("adc_start_cnt", int'(cnt), SAMPLE_PT);
            check("adc_start_single", prev_adc_start, 0);
        end
        if (cnt != 9'd0 && int'(duty) != prev_duty) begin
            vectors++;
            miscompares++;
            $display("FAIL duty_mid_period: got duty %0d at cnt %0d, expected %0d", duty, cnt, prev_duty);
        end
        prev_duty      = int'(duty);
        prev_adc_start = int'(adc_start);
    end

    initial begin
        bit ok;
        vectors        = 0;
        miscompares    = 0;
        duty_model     = 0;
        fault_model    = 0;
        prev_duty      = 0;
        prev_adc_start = 0;
        reset    = 1'b1;
        enable   = 1'b0;
        vref     = 8'd0;
        adc_data = 8'd0;
        adc_done = 1'b0;
        d_n_in   = 9'd0;

        #1 reset = 1'b0;
        #2;
        check("reset_cnt", int'(cnt), 0);
        check("reset_duty", int'(duty), 0);
        check("reset_e_n_out", int'(e_n_out), 0);
        check("reset_adc_start", int'(adc_start), 0);
        check("reset_comp_step", int'(comp_step), 0);
        check("reset_period_start", int'(period_start), 0);
        check("reset_adc_fault", int'(adc_fault), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_without_enable_cnt", int'(cnt), 0);
        check("idle_without_enable_ps", int'(period_start), 0);

        exp_duty.push_back(0);
        enable = 1'b1;

        run_period(100, 98, 10, 200);
        run_period(100, 120, 5, 300);
        run_period(255, 0, 63, 511);
        run_period(80, 60, 64, 50);
        run_period(3, 7, 1, 486);
        run_period(7, 3, 1, 487);

        for (int p = 0; p < 12; p++) begin
            int v;
            int a;
            int k;
            int dn;
            v = int'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) a = v + int'($urandom_range(0, 12)) - 6;
            else a = int'($urandom_range(0, 255));
            if (a < 0) a = 0;
            if (a > 255) a = 255;
            k = ($urandom_range(0, 5) == 0) ? 999 : int'($urandom_range(1, 63));
            dn = int'($urandom_range(0, 511));
            run_period(v, a, k, dn);
        end

        // enable dropped mid-conversion, done arriving afterwards is ignored
        wait_adc_start(ok);
        repeat (5) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        adc_done = 1'b1;
        check("disable_cnt", int'(cnt), 0);
        check("disable_duty", int'(duty), 0);
        check("disable_e_n_out", int'(e_n_out), 0);
        check("disable_period_start", int'(period_start), 0);
        check("disable_fault_kept", int'(adc_fault), fault_model);
        @(negedge clk);
        adc_done = 1'b0;
        repeat (4) @(negedge clk);
        duty_model = 0;

        exp_duty.push_back(0);
        enable = 1'b1;
        run_period(50, 50, 20, 123);

        // asynchronous reset in the middle of a conversion
        wait_adc_start(ok);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midconv_reset_cnt", int'(cnt), 0);
        check("midconv_reset_duty", int'(duty), 0);
        check("midconv_reset_e_n_out", int'(e_n_out), 0);
        check("midconv_reset_adc_start", int'(adc_start), 0);
        check("midconv_reset_comp_step", int'(comp_step), 0);
        check("midconv_reset_period_start", int'(period_start), 0);
        check("midconv_reset_adc_fault", int'(adc_fault), 0);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("post_reset_idle_cnt", int'(cnt), 0);
        check("post_reset_idle_fault", int'(adc_fault), 0);

        check("duty_queue_drained", exp_duty.size(), 0);
        check("step_queue_drained", exp_step_e.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/comp_sequencer.md
COMP_SEQUENCER -- requirements
Module: comp_sequencer

Interface
REQ-001 Parameters SHALL be one per line, name, default, meaning:
  PERIOD  512  clk cycles per switching period
  SAMPLE_PT  400  period count at which the ADC conversion starts
  ADC_TIMEOUT  64  max cycles from adc_start to adc_done
  DUTY_MAX  486  duty upper clamp (9-bit)
REQ-002 Legal parameters SHALL satisfy SAMPLE_PT + ADC_TIMEOUT + 4 < PERIOD; behaviour otherwise is undefined.
REQ-003 Ports SHALL be, one per line, name, direction, width, meaning:
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-low reset
  enable  in  1  converter run request
  vref  in  8  unsigned voltage reference code
  adc_start  out  1  one-cycle conversion request pulse
  adc_done  in  1  one-cycle pulse, adc_data valid
  adc_data  in  8  unsigned sampled output voltage
  e_n_out  out  4  two's-complement error to compensator, range -4..+4
  comp_step  out  1  one-cycle compensator sample enable
  d_n_in  in  9  compensator duty result
  duty  out  9  duty command to DPWM
  cnt  out  9  period counter to DPWM comparator
  period_start  out  1  high while cnt == 0 and running
  adc_fault  out  1  sticky conversion-timeout flag

Function
REQ-004 FSM states SHALL be IDLE, WAIT_SAMPLE, CONVERT, STEP, SETTLE, WAIT_PERIOD.
REQ-005 IDLE: cnt, duty, e_n_out, adc_start, comp_step SHALL be 0; enable=1 -> WAIT_SAMPLE next cycle with cnt starting at 0.
REQ-006 Outside IDLE, cnt SHALL increment each cycle and wrap from PERIOD-1 to 0.
REQ-007 WAIT_SAMPLE: on cnt == SAMPLE_PT, adc_start SHALL pulse for exactly one cycle and the FSM SHALL enter CONVERT.
REQ-008 CONVERT: on adc_done, err = vref - adc_data (9-bit signed) SHALL be saturated to -4..+4 and registered into e_n_out; FSM -> STEP.
REQ-009 Saturation: err > 4 -> 4'b0100; err < -4 -> 4'b1100; otherwise err[3:0].
REQ-010 STEP: comp_step SHALL be high for exactly one cycle (cycle after adc_done); FSM -> SETTLE.
REQ-011 SETTLE: after 2 cycles, d_n_in SHALL be captured into duty_pend, clamped to DUTY_MAX; FSM -> WAIT_PERIOD.
REQ-012 WAIT_PERIOD: on the cycle cnt wraps to 0, duty SHALL load duty_pend; FSM -> WAIT_SAMPLE; duty SHALL change at no other time.
REQ-013 Timeout: if ADC_TIMEOUT cycles elapse in CONVERT with no adc_done, adc_fault SHALL set, e_n_out SHALL be 0, comp_step SHALL not pulse, duty_pend SHALL remain unchanged, FSM -> WAIT_PERIOD.
REQ-014 adc_done outside CONVERT SHALL be ignored; adc_done coincident with timeout expiry SHALL count as a valid conversion.
REQ-015 enable=0 in any state SHALL force IDLE next cycle (cnt, duty, duty_pend, e_n_out = 0); adc_fault SHALL be retained.
REQ-016 At most one adc_start and one comp_step SHALL occur per period.

Reset
REQ-017 reset low SHALL asynchronously force IDLE and all outputs, duty_pend and adc_fault to 0; only reset clears adc_fault.
REQ-018 After reset release, first activity SHALL require enable=1 sampled on a rising clk edge.

Verification
REQ-019 Reset mid-CONVERT -> all outputs 0 immediately, IDLE; adc_fault 0.
REQ-020 enable=1, vref=100, adc_data=98 with adc_done 10 cycles after adc_start, d_n_in=200 -> e_n_out=0010, comp_step one cycle after adc_done, duty=200 at next cnt=0.
REQ-021 vref=100, adc_data=120 -> e_n_out=1100; vref=255, adc_data=0 -> e_n_out=0100.
REQ-022 No adc_done -> adc_fault=1 64 cycles after adc_start, no comp_step, duty unchanged across wrap.
REQ-023 d_n_in=511 -> duty=486 at next wrap.
REQ-024 enable dropped in CONVERT, late adc_done -> IDLE next cycle, duty=0, cnt=0, no comp_step.
